// File: rtl/io_responder_pkg.sv
// Shared constants for the I/O responder: bus width, address map,
// status bit positions and TX FSM state encoding.
package io_responder_pkg;

    localparam int WIDTH = 16;

    localparam logic [WIDTH-1:0] IO_ADDR_LED         = WIDTH'(0);
    localparam logic [WIDTH-1:0] IO_ADDR_UART_DATA   = WIDTH'(1);
    localparam logic [WIDTH-1:0] IO_ADDR_UART_STATUS = WIDTH'(2);
    localparam logic [WIDTH-1:0] IO_ADDR_CYCLES      = WIDTH'(3);

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_FIFO_EMPTY = 1;
    localparam int STAT_FIFO_FULL  = 2;
    localparam int STAT_OVERFLOW   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/io_responder_if.sv
// Core-side I/O port: write strobe, address, write data and combinational read data.
interface io_responder_if;
    import io_responder_pkg::*;

    logic             io_write_enable;
    logic [WIDTH-1:0] io_address;
    logic [WIDTH-1:0] io_write_data;
    logic [WIDTH-1:0] io_data_in;

    modport master (
        output io_write_enable, io_address, io_write_data,
        input  io_data_in
    );

    modport slave (
        input  io_write_enable, io_address, io_write_data,
        output io_data_in
    );

endinterface

// File: rtl/io_responder_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module io_tx_fifo
    import io_responder_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = FIFO_DEPTH_LOG2;
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(2 ** AW);

    logic [7:0]    mem [2 ** AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (count == '0);
        full     = (count == COUNT_FULL);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O slave: LED register, free-running cycle counter and a
// FIFO-buffered 8N1 UART transmitter.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 217,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          reset,
    io_responder_if.slave io,
    output logic [7:0]    leds,
    output logic          uart_tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic             wr_led;
    logic             wr_uart_data;
    logic             wr_uart_status;
    logic             wr_cycles;
    logic [WIDTH-1:0] cycles;
    logic             overflow;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic [7:0]       fifo_pop_data;
    logic             unused_wdata_hi;

    tx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud, baud_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift, shift_next;
    logic              tx_next;
    logic              fsm_pop;

    assign unused_wdata_hi = ^io.io_write_data[WIDTH-1:8];

    always_comb begin
        wr_led         = io.io_write_enable && (io.io_address == IO_ADDR_LED);
        wr_uart_data   = io.io_write_enable && (io.io_address == IO_ADDR_UART_DATA);
        wr_uart_status = io.io_write_enable && (io.io_address == IO_ADDR_UART_STATUS);
        wr_cycles      = io.io_write_enable && (io.io_address == IO_ADDR_CYCLES);
        // A same-cycle pop makes room, so only a push with no pop is dropped.
        fifo_drop      = wr_uart_data && fifo_full && !fsm_pop;
    end

    io_tx_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_uart_data),
        .push_data (io.io_write_data[7:0]),
        .pop       (fsm_pop),
        .pop_data  (fifo_pop_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds     <= '0;
            cycles   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_led) begin
                leds <= io.io_write_data[7:0];
            end
            cycles <= wr_cycles ? '0 : cycles + WIDTH'(1);
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (wr_uart_status && io.io_write_data[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        io.io_data_in = '0;
        case (io.io_address)
            IO_ADDR_LED:    io.io_data_in = WIDTH'(leds);
            IO_ADDR_CYCLES: io.io_data_in = cycles;
            IO_ADDR_UART_STATUS: begin
                io.io_data_in[STAT_TX_BUSY]    = (state != TX_IDLE);
                io.io_data_in[STAT_FIFO_EMPTY] = fifo_empty;
                io.io_data_in[STAT_FIFO_FULL]  = fifo_full;
                io.io_data_in[STAT_OVERFLOW]   = overflow;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        fsm_pop      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fsm_pop    = 1'b1;
                    shift_next = fifo_pop_data;
                    baud_next  = '0;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (baud == BAUD_LAST) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = TX_DATA;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = TX_IDLE;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            default: state_next = TX_IDLE;
        endcase

        // The line level is derived from the upcoming state so uart_tx is a plain flop.
        case (state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed/randomized bench for io_responder with CLKS_PER_BIT=4; the line
// waveform is predicted from 8N1 framing rules and compared cycle by cycle.
module tb_io_responder;
    import io_responder_pkg::*;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] leds;
    logic       uart_tx;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          line_log[$];

    io_responder_if bus();

    io_responder #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io      (bus),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level k cycles into an 8N1 frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        int unsigned slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        line_log.push_back(uart_tx);
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.io_address = a;
        #1;
        d = bus.io_data_in;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_write_enable = 1'b1;
        bus.io_address      = a;
        bus.io_write_data   = d;
        step();
        bus.io_write_enable = 1'b0;
    endtask

    // Call right after the edge that pushed b into an empty, idle transmitter.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [15:0] d;
        rd(IO_ADDR_UART_STATUS, d);
        check({tag, "_queued_status"}, d, 16'h0000);
        check({tag, "_queued_line"}, uart_tx, 1'b1);
        step();
        for (int unsigned k = 0; k < FRAME; k++) begin
            check($sformatf("%s_tx%0d", tag, k), uart_tx, frame_bit(b, k));
            rd(IO_ADDR_UART_STATUS, d);
            check($sformatf("%s_busy%0d", tag, k), d[STAT_TX_BUSY], 1'b1);
            step();
        end
        check({tag, "_end_line"}, uart_tx, 1'b1);
        rd(IO_ADDR_UART_STATUS, d);
        check({tag, "_end_status"}, d, 16'h0002);
    endtask

    initial begin
        logic [15:0]      d;
        logic [15:0]      ua;
        logic [7:0]       v;
        logic [7:0]       b1, b2, b3;
        logic [7:0]       bytes[10];
        int unsigned      idx;
        logic [FRAME-1:0] obs, exp_f;

        reset               = 1'b1;
        bus.io_write_enable = 1'b0;
        bus.io_address      = '0;
        bus.io_write_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_line", uart_tx, 1'b1);
        check("reset_leds", leds, 8'h00);
        reset = 1'b0;

        repeat (5) step();
        rd(IO_ADDR_LED, d);         check("rd_led_c5", d, 16'h0000);
        rd(IO_ADDR_UART_STATUS, d); check("rd_status_c5", d, 16'h0002);
        rd(IO_ADDR_CYCLES, d);      check("rd_cycles_c5", d, 16'd5);
        check("idle_line", uart_tx, 1'b1);
        step();
        rd(16'h0100, d);            check("rd_unmapped_100", d, 16'h0000);
        rd(IO_ADDR_UART_DATA, d);   check("rd_uart_data", d, 16'h0000);
        ua = 16'($urandom_range(65535, 4));
        rd(ua, d);                  check("rd_unmapped_rand", d, 16'h0000);

        wr(IO_ADDR_LED, {8'($urandom), 8'hA5});
        check("led_a5", leds, 8'hA5);
        rd(IO_ADDR_LED, d);         check("led_a5_rd", d, 16'h00A5);
        wr(16'h0100, 16'h00FF);
        check("led_after_unmapped", leds, 8'hA5);
        rd(IO_ADDR_UART_STATUS, d); check("status_after_unmapped", d, 16'h0002);

        for (int unsigned i = 0; i < 4; i++) begin
            v  = 8'($urandom) | 8'h01;
            ua = 16'($urandom_range(65535, 4));
            wr(IO_ADDR_LED, 16'($urandom));
            wr(IO_ADDR_LED, {8'($urandom), v});
            wr(ua, 16'($urandom));
            check($sformatf("led_rand%0d", i), leds, v);
            rd(IO_ADDR_LED, d);
            check($sformatf("led_rand%0d_rd", i), d, {8'h00, v});
        end

        wr(IO_ADDR_UART_DATA, 16'h0055);
        check_frame(8'h55, "f55");

        for (int unsigned i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        idx = 0;
        bus.io_write_enable = 1'b1;
        bus.io_address      = IO_ADDR_UART_DATA;
        for (int unsigned i = 0; i < 9; i++) begin
            bus.io_write_data = {8'($urandom), bytes[i]};
            step();
            if (i == 1) idx = line_log.size() - 1;
        end
        rd(IO_ADDR_UART_DATA, d);
        rd(IO_ADDR_UART_STATUS, d); check("burst9_status", d, 16'h0005);
        bus.io_address    = IO_ADDR_UART_DATA;
        bus.io_write_data = {8'h00, bytes[9]};
        step();
        rd(IO_ADDR_UART_STATUS, d); check("burst_overflow", d, 16'h000D);
        bus.io_address    = IO_ADDR_UART_STATUS;
        bus.io_write_data = 16'h0001;
        step();
        bus.io_write_enable = 1'b0;
        rd(IO_ADDR_UART_STATUS, d); check("overflow_cleared", d, 16'h0005);
        repeat (365) step();
        for (int unsigned j = 0; j < 9; j++) begin
            for (int unsigned k = 0; k < FRAME; k++) begin
                obs[k]   = line_log[idx + 41 * j + k];
                exp_f[k] = frame_bit(bytes[j], k);
            end
            check($sformatf("burst_frame%0d", j), obs, exp_f);
            check($sformatf("burst_gap%0d", j), line_log[idx + 41 * j + 40], 1'b1);
        end
        check("burst_done_line", uart_tx, 1'b1);
        rd(IO_ADDR_UART_STATUS, d); check("burst_done_status", d, 16'h0002);

        wr(IO_ADDR_CYCLES, 16'($urandom));
        rd(IO_ADDR_CYCLES, d);      check("cycles_cleared", d, 16'd0);
        step();
        rd(IO_ADDR_CYCLES, d);      check("cycles_one", d, 16'd1);
        repeat (65534) @(posedge clk);
        #1;
        rd(IO_ADDR_CYCLES, d);      check("cycles_max", d, 16'hFFFF);
        step();
        rd(IO_ADDR_CYCLES, d);      check("cycles_wrap", d, 16'h0000);

        b1 = 8'($urandom) & 8'hFB;
        b2 = 8'($urandom);
        wr(IO_ADDR_UART_DATA, {8'h00, b1});
        wr(IO_ADDR_UART_DATA, {8'h00, b2});
        repeat (15) step();
        check("midframe_line", uart_tx, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_line", uart_tx, 1'b1);
        check("async_reset_leds", leds, 8'h00);
        rd(IO_ADDR_UART_STATUS, d); check("async_reset_status", d, 16'h0002);
        reset = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_reset_line%0d", i), uart_tx, 1'b1);
            rd(IO_ADDR_UART_STATUS, d);
            check($sformatf("post_reset_status%0d", i), d, 16'h0002);
        end
        b3 = 8'($urandom);
        wr(IO_ADDR_UART_DATA, {8'h00, b3});
        check_frame(b3, "fpost");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
